// File: rtl/sync_pkg.sv
// Package: sync_pkg
// Shared constants and helpers for the multi-channel synchroniser/filter.
//   SYNC_STAGES_MIN / SYNC_STAGES_MAX : legal range of the synchroniser depth
//   cnt_width(len)                    : width of a counter able to hold 0..len
package sync_pkg;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;

  localparam int FILTER_LEN_MIN = 1;
  localparam int FILTER_LEN_MAX = 255;

  function automatic int cnt_width(input int len);
    return $clog2(len + 1);
  endfunction

endpackage

// File: rtl/sync_filter_chan.sv
// Module: sync_filter_chan
// One channel: STAGES-deep synchroniser, stability filter, and edge pulses.
// The filtered level changes only after the synchronised input has held a new
// value for FILTER_LEN consecutive cycles.
// Ports:
//   clk      : system clock, rising edge
//   rst      : synchronous active-high reset
//   async_in : raw asynchronous input bit
//   sync_out : filtered synchronised level
//   rise     : one-cycle pulse on sync_out 0->1
//   fall     : one-cycle pulse on sync_out 1->0
module sync_filter_chan
  import sync_pkg::*;
#(
  parameter int   STAGES     = 2,
  parameter int   FILTER_LEN = 3,
  parameter logic RESET_BIT  = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out,
  output logic rise,
  output logic fall
);

  localparam int            CW   = cnt_width(FILTER_LEN);
  localparam logic [CW-1:0] LAST = CW'(FILTER_LEN - 1);

  logic [STAGES-1:0] chain;
  logic [CW-1:0]     cnt;
  logic              s;
  logic              commit;

  assign s = chain[STAGES-1];

  // Pure flop chain: nothing may sit between these flops, or metastability
  // resolution time is lost.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour.
    if (rst) chain <= {STAGES{RESET_BIT}};
    else     chain <= {chain[STAGES-2:0], async_in};
  end

  // The count reaching LAST on a still-differing input is the commit cycle.
  assign commit = (s != sync_out) && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_out <= RESET_BIT;
      cnt      <= '0;
      rise     <= 1'b0;
      fall     <= 1'b0;
    end else begin
      // Pulses are registered alongside the level so they line up with the
      // first cycle of the new sync_out value.
      rise <= commit &&  s;
      fall <= commit && !s;
      if (s == sync_out) begin
        cnt <= '0;
      end else if (commit) begin
        sync_out <= s;
        cnt      <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/sync_filter_multi.sv
// Module: sync_filter_multi
// WIDTH independent synchroniser + glitch-filter channels for chip-boundary
// inputs (buttons, serial lines, handshakes).
// Ports:
//   clk      : system clock, rising edge
//   rst      : synchronous active-high reset
//   async_in : [WIDTH] raw asynchronous inputs
//   sync_out : [WIDTH] filtered synchronised levels
//   rise     : [WIDTH] one-cycle pulses on sync_out 0->1
//   fall     : [WIDTH] one-cycle pulses on sync_out 1->0
module sync_filter_multi
  import sync_pkg::*;
#(
  parameter int               WIDTH      = 1,
  parameter int               STAGES     = 2,
  parameter int               FILTER_LEN = 3,
  parameter logic [WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  // Reject illegal configurations at elaboration rather than silently
  // building a chain too short to be safe or a counter that never commits.
  if (STAGES < SYNC_STAGES_MIN || STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
    $error("sync_filter_multi: STAGES=%0d outside %0d..%0d",
           STAGES, SYNC_STAGES_MIN, SYNC_STAGES_MAX);
  end

  if (FILTER_LEN < FILTER_LEN_MIN || FILTER_LEN > FILTER_LEN_MAX) begin : g_bad_len
    $error("sync_filter_multi: FILTER_LEN=%0d outside %0d..%0d",
           FILTER_LEN, FILTER_LEN_MIN, FILTER_LEN_MAX);
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    sync_filter_chan #(
      .STAGES     (STAGES),
      .FILTER_LEN (FILTER_LEN),
      .RESET_BIT  (RESET_VAL[i])
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .async_in (async_in[i]),
      .sync_out (sync_out[i]),
      .rise     (rise[i]),
      .fall     (fall[i])
    );
  end

endmodule

// File: tb/tb_sync_filter_multi.sv
// Testbench: tb_sync_filter_multi
// Three instances share clk/rst:
//   dut_a : WIDTH=4, defaults, RESET_VAL=4'b0101 (reset level)
//   dut_b : WIDTH=4, defaults, RESET_VAL=0 (latency, glitch, multi, reset mid-count)
//   dut_c : WIDTH=1, STAGES=3, FILTER_LEN=1 (pass-through toggling)
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_sync_filter_multi;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] a_in, a_out, a_rise, a_fall;
  logic [3:0] b_in, b_out, b_rise, b_fall;
  logic [0:0] c_in, c_out, c_rise, c_fall;

  int asserts = 0;
  int fails   = 0;

  always #5 clk = ~clk;

  sync_filter_multi #(.WIDTH(4), .RESET_VAL(4'b0101)) dut_a (
    .clk(clk), .rst(rst), .async_in(a_in),
    .sync_out(a_out), .rise(a_rise), .fall(a_fall)
  );

  sync_filter_multi #(.WIDTH(4)) dut_b (
    .clk(clk), .rst(rst), .async_in(b_in),
    .sync_out(b_out), .rise(b_rise), .fall(b_fall)
  );

  sync_filter_multi #(.WIDTH(1), .STAGES(3), .FILTER_LEN(1)) dut_c (
    .clk(clk), .rst(rst), .async_in(c_in),
    .sync_out(c_out), .rise(c_rise), .fall(c_fall)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset level of dut_a held through reset and release; no pulses anywhere.
  task automatic test_reset();
    for (int i = 0; i < 11; i++) begin
      if (i == 3) rst = 1'b0;
      tick();
      asserts++;
      if (a_out !== 4'b0101) begin
        fails++;
        $display("FAIL reset_level cyc=%0d got=%b exp=0101", i, a_out);
      end
      asserts++;
      if (a_rise !== 4'b0000 || a_fall !== 4'b0000) begin
        fails++;
        $display("FAIL reset_pulse cyc=%0d rise=%b fall=%b exp=0000", i, a_rise, a_fall);
      end
      asserts++;
      if (b_out !== 4'b0000 || b_rise !== 4'b0000 || b_fall !== 4'b0000 ||
          c_out !== 1'b0 || c_rise !== 1'b0 || c_fall !== 1'b0) begin
        fails++;
        $display("FAIL reset_zero cyc=%0d b=%b/%b/%b c=%b/%b/%b exp all 0",
                 i, b_out, b_rise, b_fall, c_out, c_rise, c_fall);
      end
    end
  endtask

  // Channel 0 goes high before edge k; commit at edge k+4.
  task automatic test_latency();
    b_in[0] = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      asserts++;
      if (b_out[0] !== (i >= 4)) begin
        fails++;
        $display("FAIL latency_level edge=k+%0d got=%b exp=%b", i, b_out[0], (i >= 4));
      end
      asserts++;
      if (b_rise[0] !== (i == 4) || b_fall[0] !== 1'b0) begin
        fails++;
        $display("FAIL latency_pulse edge=k+%0d rise=%b fall=%b exp_rise=%b exp_fall=0",
                 i, b_rise[0], b_fall[0], (i == 4));
      end
    end
    b_in[0] = 1'b0;
    repeat (8) tick();
  endtask

  // Channel 2: a 2-cycle glitch is rejected; a 3-cycle pulse passes.
  task automatic test_glitch();
    b_in[2] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 1) b_in[2] = 1'b0;
      asserts++;
      if (b_out[2] !== 1'b0 || b_rise[2] !== 1'b0 || b_fall[2] !== 1'b0) begin
        fails++;
        $display("FAIL glitch_reject cyc=%0d out=%b rise=%b fall=%b exp=0/0/0",
                 i, b_out[2], b_rise[2], b_fall[2]);
      end
    end
    b_in[2] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (i == 2) b_in[2] = 1'b0;
      asserts++;
      if (b_out[2] !== (i >= 4 && i < 7)) begin
        fails++;
        $display("FAIL glitch_pass_level cyc=%0d got=%b exp=%b", i, b_out[2], (i >= 4 && i < 7));
      end
      asserts++;
      if (b_rise[2] !== (i == 4) || b_fall[2] !== (i == 7)) begin
        fails++;
        $display("FAIL glitch_pass_pulse cyc=%0d rise=%b fall=%b exp=%b/%b",
                 i, b_rise[2], b_fall[2], (i == 4), (i == 7));
      end
    end
  endtask

  // Three channels change together and commit/pulse in the same cycle.
  task automatic test_multi();
    logic [3:0] exp_out, exp_rise;
    b_in = 4'b1011;
    for (int i = 0; i < 7; i++) begin
      tick();
      exp_out  = (i >= 4) ? 4'b1011 : 4'b0000;
      exp_rise = (i == 4) ? 4'b1011 : 4'b0000;
      asserts++;
      if (b_out !== exp_out) begin
        fails++;
        $display("FAIL multi_level cyc=%0d got=%b exp=%b", i, b_out, exp_out);
      end
      asserts++;
      if (b_rise !== exp_rise || b_fall !== 4'b0000) begin
        fails++;
        $display("FAIL multi_pulse cyc=%0d rise=%b fall=%b exp=%b/0000",
                 i, b_rise, b_fall, exp_rise);
      end
    end
    b_in = 4'b0000;
    for (int i = 0; i < 7; i++) begin
      tick();
      asserts++;
      if (b_fall !== ((i == 4) ? 4'b1011 : 4'b0000)) begin
        fails++;
        $display("FAIL multi_fall cyc=%0d got=%b exp=%b", i, b_fall,
                 ((i == 4) ? 4'b1011 : 4'b0000));
      end
    end
    repeat (2) tick();
  endtask

  // Channel 1 count is discarded by a reset three edges in; latency restarts.
  task automatic test_reset_mid();
    b_in[1] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      asserts++;
      if (b_out[1] !== 1'b0) begin
        fails++;
        $display("FAIL mid_pre cyc=%0d got=%b exp=0", i, b_out[1]);
      end
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    asserts++;
    if (b_out !== 4'b0000 || b_rise !== 4'b0000 || b_fall !== 4'b0000) begin
      fails++;
      $display("FAIL mid_reset out=%b rise=%b fall=%b exp=0000", b_out, b_rise, b_fall);
    end
    for (int j = 1; j < 9; j++) begin
      tick();
      asserts++;
      if (b_out[1] !== (j >= 5)) begin
        fails++;
        $display("FAIL mid_level j=%0d got=%b exp=%b", j, b_out[1], (j >= 5));
      end
      asserts++;
      if (b_rise[1] !== (j == 5) || b_fall[1] !== 1'b0) begin
        fails++;
        $display("FAIL mid_pulse j=%0d rise=%b fall=%b exp=%b/0", j, b_rise[1], b_fall[1], (j == 5));
      end
    end
    b_in[1] = 1'b0;
    repeat (8) tick();
  endtask

  // FILTER_LEN=1, STAGES=3: output follows input 3 edges later, one pulse per toggle.
  task automatic test_passthrough();
    logic val = 1'b0;
    int   n_rise = 0;
    int   n_fall = 0;
    for (int t = 0; t < 20; t++) begin
      val  = ~val;
      c_in = val;
      for (int i = 0; i < 5; i++) begin
        tick();
        n_rise += int'(c_rise);
        n_fall += int'(c_fall);
        asserts++;
        if (c_out !== ((i >= 3) ? val : ~val)) begin
          fails++;
          $display("FAIL pass_level t=%0d cyc=%0d got=%b exp=%b", t, i, c_out,
                   ((i >= 3) ? val : ~val));
        end
        asserts++;
        if (c_rise !== (i == 3 && val) || c_fall !== (i == 3 && !val)) begin
          fails++;
          $display("FAIL pass_pulse t=%0d cyc=%0d rise=%b fall=%b exp=%b/%b", t, i,
                   c_rise, c_fall, (i == 3 && val), (i == 3 && !val));
        end
      end
    end
    asserts++;
    if (n_rise != 10 || n_fall != 10) begin
      fails++;
      $display("FAIL pass_count rise=%0d fall=%0d exp=10/10", n_rise, n_fall);
    end
  endtask

  initial begin
    rst  = 1'b1;
    a_in = 4'b0101;
    b_in = 4'b0000;
    c_in = 1'b0;
    test_reset();
    test_latency();
    test_glitch();
    test_multi();
    test_reset_mid();
    test_passthrough();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
